// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory system between the fetch stage (read-only)
//            and the memory stage (read/write). One transaction is in flight
//            at a time. The data port has priority, and a streak counter
//            stops fetch from being starved.
// Ports    : clk/rst          clock, asynchronous active-low reset
//            if_*             fetch request/response port
//            d_*              data request/response port
//            mem_*            memory system request/response port
//            owner            00 idle, 01 fetch busy, 10 data busy
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  output logic        if_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic [1:0]  owner
);

  // State encoding doubles as the owner output.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_BUSY = 2'b01,
    D_BUSY  = 2'b10
  } state_e;

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_STREAK);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;

  logic w_d_pend;
  logic w_f_pend;
  logic w_fin;

  assign w_d_pend = d_rd | d_wr;
  assign w_f_pend = if_req;
  // An error ends the transaction exactly like a normal completion.
  assign w_fin    = mem_done | mem_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        // Data wins a tie unless fetch has already lost MAX_STREAK times.
        if (w_d_pend && !(w_f_pend && (streak_q == C_MAX_STREAK))) begin
          state_d = D_BUSY;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_wr;
          if (!w_f_pend) begin
            streak_d = 4'd0;
          end else if (streak_q != C_MAX_STREAK) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (w_f_pend) begin
          state_d  = IF_BUSY;
          addr_d   = if_addr;
          wdata_d  = 16'd0;
          wr_d     = 1'b0;
          streak_d = 4'd0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (w_fin) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic w_if_own;
  logic w_d_own;

  assign w_if_own = (state_q == IF_BUSY);
  assign w_d_own  = (state_q == D_BUSY);

  assign owner     = state_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = w_if_own | (w_d_own & ~wr_q);
  assign mem_wr    = w_d_own & wr_q;

  assign if_done  = w_if_own & w_fin;
  assign if_err   = w_if_own & mem_err;
  assign if_rdata = if_done ? mem_rdata : 16'd0;

  assign d_done   = w_d_own & w_fin;
  assign d_err    = w_d_own & mem_err;
  assign d_rdata  = (d_done & ~wr_q) ? mem_rdata : 16'd0;

  // Stalls are gated by reset so that every output is low while in reset,
  // even if a requester is already asserting.
  assign if_stall = rst & if_req & ~if_done;
  assign d_stall  = rst & w_d_pend & ~d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, scoreboard-checked bench for mem_port_arbiter.
//            Stimulus pushes the expected completion into a queue; a monitor
//            pops and compares whenever a done pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done, if_stall, if_err;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_stall, d_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_err;
  logic [1:0]  owner;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        is_d;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];

  mem_port_arbiter #(.MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall), .if_err(if_err),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_err(mem_err), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (if_done || d_done)) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {62'd0, d_done, if_done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_port", {62'd0, d_done, if_done}, e.is_d ? 64'd2 : 64'd1);
        chk("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        chk("other_rdata", e.is_d ? if_rdata : d_rdata, 0);
        chk("if_err", if_err, e.is_d ? 1'b0 : e.err);
        chk("d_err", d_err, e.is_d ? e.err : 1'b0);
      end
    end
  end

  // Play the memory system for one transaction: wait for a request, check
  // the port every busy cycle, and complete it in busy cycle number lat.
  task automatic serve(input int lat, input logic is_d, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] rdata, input logic err);
    int n = 0;
    while (!(mem_rd || mem_wr) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("busy_timeout", 0, 1);
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk("owner_busy", owner, is_d ? 2'b10 : 2'b01);
      chk("mem_addr", mem_addr, addr);
      chk("mem_rd", mem_rd, !wr);
      chk("mem_wr", mem_wr, wr);
      if (wr) chk("mem_wdata", mem_wdata, wdata);
      if (c == lat) begin
        mem_done  = !err;
        mem_err   = err;
        mem_rdata = rdata;
        #1;
        chk("stall_done", is_d ? d_stall : if_stall, 0);
      end else begin
        chk("stall_busy", is_d ? d_stall : if_stall, 1);
      end
    end
    @(posedge clk); #1;
    mem_done  = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 16'd0;
    chk("owner_bubble", owner, 0);
    chk("rw_bubble", {mem_rd, mem_wr}, 0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0010;
    d_rd = 1'b1; d_wr = 1'b0; d_addr = 16'h0300; d_wdata = 16'h0000;
    mem_rdata = 16'd0; mem_done = 1'b0; mem_err = 1'b0;

    // Reset with both requests pending: everything low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_out", {if_rdata, if_done, if_stall, if_err}, 0);
    chk("rst_d_out", {d_rdata, d_done, d_stall, d_err}, 0);
    chk("rst_mem_out", {mem_addr, mem_wdata, mem_rd, mem_wr}, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b1;

    // Data wins the first grant after release.
    @(posedge clk); #1;
    chk("first_grant", owner, 2'b10);
    q.push_back('{is_d: 1'b1, rdata: 16'h5555, err: 1'b0});
    serve(1, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h5555, 1'b0);
    d_rd = 1'b0;

    // Single fetch, three busy cycles.
    q.push_back('{is_d: 1'b0, rdata: 16'h1234, err: 1'b0});
    serve(3, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0);
    if_req = 1'b0;
    #1 chk("if_stall_after", if_stall, 0);

    // Data write: rdata forced to 0 even though memory returns data.
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    q.push_back('{is_d: 1'b1, rdata: 16'h0000, err: 1'b0});
    serve(2, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'hFFFF, 1'b0);
    d_wr = 1'b0;

    // Read and write together: write wins.
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0204; d_wdata = 16'h1357;
    q.push_back('{is_d: 1'b1, rdata: 16'h0000, err: 1'b0});
    serve(1, 1'b1, 1'b1, 16'h0204, 16'h1357, 16'hAAAA, 1'b0);
    d_rd = 1'b0; d_wr = 1'b0;

    // Error on a fetch ends it with if_err, d_err stays low.
    if_req = 1'b1; if_addr = 16'h0020;
    q.push_back('{is_d: 1'b0, rdata: 16'h0BAD, err: 1'b1});
    serve(2, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0BAD, 1'b1);
    if_req = 1'b0;

    // Starvation bound: D,D,D,D,F repeated twice with both held high.
    if_req = 1'b1; if_addr = 16'h0030;
    d_rd = 1'b1; d_addr = 16'h0400;
    for (int i = 0; i < 10; i++) begin
      logic fetch_turn;
      logic [15:0] rv;
      fetch_turn = (i % 5) == 4;
      rv = 16'hC000 + 16'(i);
      q.push_back('{is_d: !fetch_turn, rdata: rv, err: 1'b0});
      serve(1, !fetch_turn, 1'b0, fetch_turn ? 16'h0030 : 16'h0400, 16'h0, rv, 1'b0);
    end
    if_req = 1'b0; d_rd = 1'b0;

    // Reset in the middle of a data write: abandoned, no done.
    @(posedge clk); #1;
    d_wr = 1'b1; d_addr = 16'h0500; d_wdata = 16'h7777;
    @(posedge clk); #1;
    chk("pre_rst_wr", mem_wr, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_wr_drop", mem_wr, 0);
    chk("async_owner", owner, 0);
    chk("async_d_done", {d_done, d_stall}, 0);
    d_wr = 1'b0;
    if_req = 1'b1; if_addr = 16'h0040;
    @(posedge clk); #1;
    rst = 1'b1;
    q.push_back('{is_d: 1'b0, rdata: 16'h4242, err: 1'b0});
    serve(2, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h4242, 1'b0);
    if_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one mem_system instance (Addr/DataIn/Rd/Wr in; DataOut/Done/Stall/CacheHit/err out) between the fetch stage (read-only) and the memory stage (read/write), giving a single unified-memory configuration.
- Sits between the fetch/memory pipeline stages and the memory system.
- Accepts one transaction at a time through a 3-state FSM.
- Data port has priority; a streak counter bounds fetch starvation.

Parameters:
MAX_STREAK, 4, consecutive data grants allowed while if_req is waiting before fetch is forced to win (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request, level; held until if_done
if_addr  in  16  fetch address, stable while if_req
if_rdata  out  16  instruction data, valid when if_done
if_done  out  1  one-cycle completion pulse to fetch
if_stall  out  1  fetch must hold (if_req & ~if_done)
if_err  out  1  fetch transaction ended in error, pulses with if_done
d_rd  in  1  data read request, level; held until d_done
d_wr  in  1  data write request, level; held until d_done
d_addr  in  16  data address
d_wdata  in  16  write data
d_rdata  out  16  read data, valid when d_done
d_done  out  1  one-cycle completion pulse to data port
d_stall  out  1  (d_rd|d_wr) & ~d_done
d_err  out  1  data transaction ended in error, pulses with d_done
mem_addr  out  16  to mem_system Addr
mem_wdata  out  16  to mem_system DataIn
mem_rd  out  1  to mem_system Rd
mem_wr  out  1  to mem_system Wr
mem_rdata  in  16  from mem_system DataOut
mem_done  in  1  from mem_system Done
mem_err  in  1  from mem_system err
owner  out  2  00 idle, 01 fetch, 10 data

Behaviour:
- Reset (rst=0, async): state IDLE, streak=0, address/data/op latches=0; every output 0.
- States: IDLE, IF_BUSY, D_BUSY. owner encodes state.
- IDLE grant (registered; evaluated every IDLE cycle):
  - data pending = d_rd|d_wr; fetch pending = if_req.
  - Only one pending -> grant it.
  - Both pending -> data wins unless streak==MAX_STREAK, then fetch wins.
  - On grant, latch addr, wdata and op (d_wr wins over d_rd if both are high) into registers.
- Latency: request seen in IDLE at cycle N -> mem_rd/mem_wr high from N+1.
- Busy states:
  - mem_rd (fetch, or data read) or mem_wr (data write) held high continuously.
  - mem_addr/mem_wdata driven from the latches, stable until the done cycle.
  - Requester input changes during busy are ignored.
- Completion:
  - In the cycle mem_done=1 or mem_err=1, combinationally pulse the owner's done.
  - Pass mem_rdata to the owner's rdata; 0 on writes.
  - Owner's err = mem_err in that same cycle.
  - FSM returns to IDLE next cycle and mem_rd/mem_wr drop.
  - This gives a mandatory one-cycle IDLE bubble between transactions.
- Non-owner rdata/done/err are 0; non-owner stall follows its own request.
- Streak counter (4-bit):
  - +1 on each data grant while if_req=1, saturating at MAX_STREAK.
  - Cleared on any fetch grant.
  - Cleared on a data grant with if_req=0.
- mem_err: terminates the transaction exactly like done; the requester decides on retry. No sticky error.
- Requester dropping its request mid-transaction: the transaction still completes and its done still pulses.
- Reset mid-transaction: outputs drop asynchronously and the transaction is abandoned. No done or err is issued.
- mem_done/mem_err seen in IDLE: ignored.

Test Plan:
- Reset: rst=0 with if_req=1, d_rd=1 -> all outputs 0, owner=00. Release -> owner=01? No: data wins, owner=10 one cycle after release.
- Single fetch: if_req=1, if_addr=0x0010; mem_done after 3 busy cycles with mem_rdata=0x1234 -> mem_rd high 3 cycles with mem_addr=0x0010; if_done=1 and if_rdata=0x1234 in the done cycle; if_stall high until then; owner=00 the next cycle.
- Data write: d_wr=1, d_addr=0x0200, d_wdata=0xBEEF -> mem_wr=1 with stable addr/data; d_rdata=0 at done.
- Simultaneous d_rd and d_wr: d_wr wins, so mem_wr=1 and mem_rd=0.
- Starvation, MAX_STREAK=4: if_req and d_rd held high continuously -> grant order D,D,D,D,F,D,...; streak returns to 0 after the F grant.
- Error: mem_err=1 during a fetch with mem_done=0 -> if_done=1 and if_err=1 for one cycle; FSM to IDLE; d_err stays 0.
- Mid-transaction reset: rst low during D_BUSY -> mem_wr falls without waiting for clk; no d_done. After release, a pending if_req is granted normally.
